// File: rtl/sum_up_accumulator.sv
// sum_up_accumulator: sums 1..N serially (IDLE/ACC/DONE); ports clk, rst, start, N, ack -> busy, done, count, sum
module sum_up_accumulator #(
  parameter int N_W   = 4,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   N,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   count,
  output logic [SUM_W-1:0] sum
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [N_W-1:0] n_reg;
  logic [N_W-1:0] nxt;
  always_comb nxt = count + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      sum   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_reg <= N;
          count <= '0;
          sum   <= '0;
          state <= (N == '0) ? DONE : ACC;
          busy  <= (N != '0);
          done  <= (N == '0);
        end
        ACC: begin
          count <= nxt;
          sum   <= sum + {{(SUM_W-N_W){1'b0}}, nxt};
          if (nxt == n_reg) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: if (ack) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
